// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_INSTR_W  = 32;
  localparam int unsigned IF_PC_STEP  = 4;
  localparam int unsigned IF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Default-width view of one prefetch entry: fetched word plus the PC after it.
  typedef struct packed {
    logic [IF_INSTR_W-1:0] instr;
    logic [IF_ADDR_W-1:0]  next_pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_fifo.sv
// First-word-fall-through FIFO with a flush that outranks push and pop.
module prefetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Issue gating upstream guarantees a slot for every accepted fetch.
  assert property (@(posedge clk) disable iff (!rst) !(push && full))
    else $error("prefetch_fifo: push into full FIFO");

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential req/ack fetcher feeding a prefetch FIFO, flushed on branches.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter  int unsigned       ADDR_W   = IF_ADDR_W,
  parameter  int unsigned       INSTR_W  = IF_INSTR_W,
  parameter  int unsigned       DEPTH    = 4,
  parameter  int unsigned       PC_STEP  = IF_PC_STEP,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
  localparam int unsigned       CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [CNT_W-1:0]   fifo_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  next_pc;
  } entry_t;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  entry_t            wr_entry;
  entry_t            rd_entry;

  // Occupancy after this edge's push/pop decides whether another fetch may issue.
  always_comb begin
    pop         = !empty && !freeze && !branch_taken;
    push        = (state == REQ) && imem_ack && !branch_taken;
    count_after = count + CNT_W'(push) - CNT_W'(pop);
    pc_inc      = fetch_pc + ADDR_W'(PC_STEP);
    wr_entry    = '{instr: imem_rdata, next_pc: pc_inc};
  end

  // In DROP the stale address is held until the memory accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            fetch_pc <= branch_address;
          end else if (!full || pop) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (branch_taken) begin
              fetch_pc <= branch_address;
              imem_req <= 1'b0;
              state    <= IDLE;
            end else begin
              fetch_pc <= pc_inc;
              if (count_after < CNT_W'(DEPTH)) begin
                imem_addr <= pc_inc;
              end else begin
                imem_req <= 1'b0;
                state    <= IDLE;
              end
            end
          end else if (branch_taken) begin
            fetch_pc <= branch_address;
            state    <= DROP;
          end
        end
        DROP: begin
          if (branch_taken) begin
            fetch_pc <= branch_address;
          end
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  prefetch_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(branch_taken),
    .push (push),
    .pop  (pop),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign valid_out       = !empty;
  assign instruction_out = rd_entry.instr;
  assign pc_out          = rd_entry.next_pc;
  assign fifo_count      = count;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomised and directed bench for if_prefetch_stage against a request/queue reference model.
module tb_if_prefetch_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  // Memory behaviour: 0 = always ack, 1 = fixed latency, 2 = random ack.
  int ack_mode = 0;
  int lat = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic        m_busy = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_pc = '0;
  int          m_wait = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .valid_out      (valid_out),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .fifo_count     (fifo_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a << 3);
  endfunction

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request, a queue of fetched entries.
  always @(posedge clk or negedge rst) begin : model
    bit do_pop;
    if (!rst) begin
      q.delete();
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_addr  = '0;
      m_pc    = 32'h0;
      m_wait  = 0;
    end else begin
      do_pop = (q.size() != 0) && !freeze && !branch_taken;
      if (branch_taken) begin
        q.delete();
        m_pc = branch_address;
        if (m_busy) begin
          if (imem_ack) begin
            m_busy  = 1'b0;
            m_stale = 1'b0;
          end else begin
            m_stale = 1'b1;
            m_wait++;
          end
        end
      end else begin
        if (do_pop) void'(q.pop_front());
        if (m_busy && imem_ack) begin
          if (!m_stale) begin
            q.push_back('{instr: mem_word(m_addr), pc: m_addr + 32'd4});
            m_pc = m_addr + 32'd4;
          end
          m_busy = !m_stale && (q.size() < DEPTH);
          m_stale = 1'b0;
          if (m_busy) begin
            m_addr = m_pc;
            m_wait = 0;
          end
        end else if (m_busy) begin
          m_wait++;
        end else if (q.size() < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_pc;
          m_wait = 0;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    expect_eq("valid_out", 32'(valid_out), 32'(q.size() != 0));
    expect_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    if (q.size() != 0) begin
      expect_eq("instruction_out", instruction_out, q[0].instr);
      expect_eq("pc_out", pc_out, q[0].pc);
    end
    expect_eq("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) expect_eq("imem_addr", imem_addr, m_addr);
  end

  // Apply inputs for the next rising edge, then return at the following falling edge.
  task automatic tick(input logic fz, input logic br, input logic [31:0] ba);
    freeze         = fz;
    branch_taken   = br;
    branch_address = ba;
    imem_rdata     = mem_word(m_addr);
    case (ack_mode)
      0:       imem_ack = 1'b1;
      1:       imem_ack = m_busy && (m_wait >= lat - 1);
      default: imem_ack = m_busy && ($urandom_range(0, 99) < 60);
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [31:0] ba;

    // Zero-latency memory, no stall.
    ack_mode = 0;
    do_reset();
    expect_eq("rst_imem_req", 32'(imem_req), 32'd0);
    expect_eq("rst_valid", 32'(valid_out), 32'd0);
    expect_eq("rst_count", 32'(fifo_count), 32'd0);
    expect_eq("rst_instr", instruction_out, 32'd0);
    expect_eq("rst_pc", pc_out, 32'd0);
    tick(0, 0, 0);
    expect_eq("t1_req", 32'(imem_req), 32'd1);
    expect_eq("t1_addr0", imem_addr, 32'h0);
    expect_eq("t1_no_valid", 32'(valid_out), 32'd0);
    tick(0, 0, 0);
    expect_eq("t1_valid", 32'(valid_out), 32'd1);
    expect_eq("t1_pc4", pc_out, 32'h4);
    tick(0, 0, 0);
    expect_eq("t1_pc8", pc_out, 32'h8);
    tick(0, 0, 0);
    expect_eq("t1_pc12", pc_out, 32'hC);
    repeat (6) tick(0, 0, 0);

    // Stall fills exactly DEPTH entries, then drains in order.
    do_reset();
    repeat (10) tick(1, 0, 0);
    expect_eq("t2_count_full", 32'(fifo_count), 32'd4);
    expect_eq("t2_req_idle", 32'(imem_req), 32'd0);
    expect_eq("t2_head", pc_out, 32'h4);
    tick(0, 0, 0);
    expect_eq("t2_resume_addr", imem_addr, 32'h10);
    expect_eq("t2_resume_req", 32'(imem_req), 32'd1);
    expect_eq("t2_head2", pc_out, 32'h8);
    repeat (8) tick(0, 0, 0);

    // Latency 3; branch while address 8 is outstanding.
    ack_mode = 1; lat = 3;
    do_reset();
    n = 0;
    while (!(m_busy && m_addr == 32'h8) && n < 30) begin tick(0, 0, 0); n++; end
    expect_eq("t3_reach8", 32'(n < 30), 32'd1);
    tick(0, 0, 0);
    tick(0, 1, 32'h100);
    n = 0;
    while (!(imem_req && imem_addr != 32'h8) && n < 20) begin tick(0, 0, 0); n++; end
    expect_eq("t3_redirect_addr", imem_addr, 32'h100);
    n = 0;
    while (!valid_out && n < 20) begin tick(0, 0, 0); n++; end
    expect_eq("t3_first_pc", pc_out, 32'h104);
    repeat (6) tick(0, 0, 0);

    // Branch coincides with ack and a possible pop, two entries held.
    ack_mode = 0;
    do_reset();
    repeat (3) tick(1, 0, 0);
    expect_eq("t4_count2", 32'(fifo_count), 32'd2);
    tick(0, 1, 32'h40);
    expect_eq("t4_count0", 32'(fifo_count), 32'd0);
    expect_eq("t4_valid0", 32'(valid_out), 32'd0);
    expect_eq("t4_req0", 32'(imem_req), 32'd0);
    tick(0, 0, 0);
    expect_eq("t4_target", imem_addr, 32'h40);
    repeat (5) tick(0, 0, 0);

    // Back-to-back branches while the stale request is pending.
    ack_mode = 1; lat = 3;
    do_reset();
    tick(0, 0, 0);
    tick(0, 1, 32'h200);
    tick(0, 1, 32'h300);
    n = 0;
    while (!(imem_req && imem_addr != 32'h0) && n < 20) begin tick(0, 0, 0); n++; end
    expect_eq("t5_addr", imem_addr, 32'h300);
    n = 0;
    while (!valid_out && n < 20) begin tick(0, 0, 0); n++; end
    expect_eq("t5_first_pc", pc_out, 32'h304);
    repeat (4) tick(0, 0, 0);

    // Asynchronous reset mid-request with three entries buffered.
    ack_mode = 0;
    do_reset();
    repeat (4) tick(1, 0, 0);
    expect_eq("t6_count3", 32'(fifo_count), 32'd3);
    expect_eq("t6_req1", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    expect_eq("t6_async_req", 32'(imem_req), 32'd0);
    expect_eq("t6_async_valid", 32'(valid_out), 32'd0);
    expect_eq("t6_async_count", 32'(fifo_count), 32'd0);
    freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick(0, 0, 0);
    expect_eq("t6_restart_req", 32'(imem_req), 32'd1);
    expect_eq("t6_restart_addr", imem_addr, 32'h0);

    // Top-of-address-space wrap.
    repeat (2) tick(0, 0, 0);
    tick(0, 1, 32'hFFFF_FFF8);
    n = 0;
    while (!valid_out && n < 20) begin tick(0, 0, 0); n++; end
    expect_eq("wrap_pc1", pc_out, 32'hFFFF_FFFC);
    tick(0, 0, 0);
    expect_eq("wrap_pc2", pc_out, 32'h0);

    // Randomised segments across memory behaviours.
    for (int seg = 0; seg < 4; seg++) begin
      ack_mode = (seg % 2 == 0) ? 2 : 1;
      lat = $urandom_range(1, 4);
      do_reset();
      for (int c = 0; c < 1200; c++) begin
        case ($urandom_range(0, 3))
          0:       ba = $urandom;
          1:       ba = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
          default: ba = 32'($urandom_range(0, 255)) * 32'd4;
        endcase
        tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, ba);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
